fetch_unit: RTL
===============

# fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle RISC-V core. It holds the PC, which addresses `inst_mem`, and computes next-PC from sequential or branch/jump redirect inputs. It gates execution into free-run or button-driven single-step mode, and it raises a one-cycle `advance` strobe that downstream write enables (`reg_write`, `mem_write`) AND with, so that each instruction commits exactly once per PC update.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset and the target on wrap-around.
- `IMEM_WORDS`, 64, instruction memory depth in 32-bit words. The PC wraps at `IMEM_WORDS*4`.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high.
- `run_mode`  in  1  raw switch: 1 = free-run, 0 = single-step. Unsynchronized.
- `step`  in  1  raw button level. A rising edge requests one instruction. Unsynchronized.
- `redirect`  in  1  current instruction is a taken branch or jump.
- `redirect_target`  in  32  byte address of the redirect target.
- `halt_req`  in  1  current instruction is `ebreak`/`ecall`.
- `pc`  out  32  current instruction address.
- `pc_plus4`  out  32  combinational `pc + 4`, used as the JAL/JALR link value.
- `advance`  out  1  PC updates at the next edge; the current instruction commits.
- `state`  out  2  FSM state, shown on the LEDs.
- `fault`  out  1  sticky misaligned-target flag.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- **Synchronizers.** `run_mode` and `step` each pass through a 2-flop synchronizer. `step` also goes through a third flop for rising-edge detection: `step_edge = s1 & ~s2`.
- **FSM states** (`fetch_state_t`): `RUN`=0, `STEP_WAIT`=1, `HALT`=2, `FAULT`=3.
- **`RUN`.** `advance` = 1 every cycle unless suppressed (see the next bullets). The FSM goes to `STEP_WAIT` when the synchronized `run_mode` = 0.
- **`STEP_WAIT`.** `advance` = `step_edge`, unless suppressed. The FSM goes to `RUN` when the synchronized `run_mode` = 1.
- **Halt.** If `advance` would assert and `halt_req` = 1: `advance` is forced to 0, the PC holds, and the FSM goes to `HALT`.
- **Fault.** If `advance` would assert, `redirect` = 1 and `redirect_target[1:0]` != 0: `advance` is forced to 0, the PC holds, `fault` is set, and the FSM goes to `FAULT`.
- **Priority.** `halt_req` takes priority over a misaligned target, which takes priority over a normal advance.
- **`HALT` and `FAULT`** are terminal: `advance` = 0 and `pc` is frozen. Only `reset` exits them.
- **Next PC** on advance: `redirect ? redirect_target : pc + 4`.
- **Wrap.** If the computed value is >= `IMEM_WORDS*4`, the PC loads `RESET_PC` instead.
- **Width rules.** All PC arithmetic is 32-bit unsigned; `pc + 4` overflow is discarded.
- **Instruction counter.** `instr_count` increments by 1 on every `advance` and wraps from 32'hFFFF_FFFF to 0.
- **Reset values.**
  - `pc` = `RESET_PC`, `state` = `RUN`, `fault` = 0, `instr_count` = 0.
  - All synchronizer flops = 0.
  - `advance` follows from the state: it is 1 in the first cycle after reset release only if the synchronized `run_mode` is 1. Since the synchronizers reset to 0, the FSM first moves to `STEP_WAIT` in that cycle.

## Timing
- `pc`, `state`, `fault` and `instr_count` are registered and change only on the rising edge of `clk`.
- `advance` and `pc_plus4` are combinational from the current state, `pc`, and the same-cycle `redirect`/`halt_req`.
- **Step latency.** `step` rises before edge k; `s1` = 1 after edge k+1; `advance` is high for exactly one cycle, between edges k+1 and k+2; the PC updates at edge k+2.
  - Holding `step` high yields exactly one advance.
  - A new step requires `step` low for at least 2 cycles.
- **Mode-switch latency.** 2 edges from the raw change to the FSM acting on it.
- **`reset` asserted mid-operation.** All registers take their reset values immediately (asynchronously). A pending step edge is discarded.
- **Deassertion.** `reset` deassertion is assumed synchronous to `clk` externally.

## Structure
- **Package `riscv_pkg`:**
  - `XLEN` = 32.
  - `fetch_state_t` enum (2-bit).
  - `INSTR_BYTES` = 4.
- **Sub-module `sync_edge_detect`:** a parameterized-width 2-flop synchronizer plus a registered-previous flop, with outputs `sync` and `rise`.
  - Instantiated once for `step` and once for `run_mode`; the `rise` output of the `run_mode` instance is unused.
- **FSM and PC logic** live in `fetch_unit`.

## Test plan
- **Free-run sequential.** Reset with `run_mode`=1, `redirect`=0, `halt_req`=0 → after synchronizer settle, `pc` = 0, 4, 8, … one step per cycle. With `IMEM_WORDS`=4, `pc` goes 12 → 0 and `instr_count` keeps incrementing.
- **Redirect.** `redirect`=1 with `redirect_target`=32'h20 while `pc`=8 → next `pc` = 32'h20 and `instr_count` +1. With target 32'h22 → `pc` stays 8, `fault`=1, `state`=3, `advance`=0 thereafter.
- **Single-step.** `run_mode`=0, then hold `step` high for 10 cycles → exactly one `advance` pulse, 2 cycles after the rise, and `pc` 0 → 4. A second press after ≥2 low cycles → `pc` = 8.
- **Halt priority.** `halt_req`=1 together with a misaligned redirect in `RUN` → `state`=2, `fault`=0, `pc` frozen, `advance`=0 for 20 cycles.
- **Mode toggle.** Switch `run_mode` 1→0 mid-run → `state` changes to `STEP_WAIT` 2 edges later and `pc` freezes. Switch back → advance resumes within 2 edges.
- **Async reset.** Assert `reset` between clock edges in `RUN` at `pc`=32'h10 → `pc`=0, `instr_count`=0 and `state`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types and constants for the RISC-V front end.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STEP_WAIT = 2'd1,
        HALT      = 2'd2,
        FAULT     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for asynchronous inputs, plus a delayed copy for rising-edge detection.
module sync_edge_detect #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_s0, r_s1, r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s0 <= i_d;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign o_sync = r_s1;
    assign o_rise = r_s1 & ~r_s2;

endmodule

// File: rtl/fetch_unit.sv
// PC holder and fetch sequencer: free-run / single-step gating, halt and misaligned-target trapping.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_run_mode,
    input  logic            i_step,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_halt_req,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_advance,
    output logic [1:0]      o_state,
    output logic            o_fault,
    output logic [XLEN-1:0] o_instr_count
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * INSTR_BYTES);

    fetch_state_t    r_state, w_next_state;
    logic [XLEN-1:0] r_pc, r_count, w_next_pc, w_pc_raw;
    logic            r_fault, w_set_fault, w_advance, w_want;
    logic            w_run, w_step_rise, w_run_rise_unused, w_step_sync_unused;

    sync_edge_detect #(.W(1)) u_run_sync (
        .i_clk (i_clk),
        .i_rst (i_reset),
        .i_d   (i_run_mode),
        .o_sync(w_run),
        .o_rise(w_run_rise_unused)
    );

    sync_edge_detect #(.W(1)) u_step_sync (
        .i_clk (i_clk),
        .i_rst (i_reset),
        .i_d   (i_step),
        .o_sync(w_step_sync_unused),
        .o_rise(w_step_rise)
    );

    assign o_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);
    assign w_pc_raw   = i_redirect ? i_redirect_target : o_pc_plus4;
    assign w_next_pc  = (w_pc_raw >= PC_LIMIT) ? RESET_PC : w_pc_raw;

    // RUN gates on the synchronized switch so the cycle that leaves RUN does not commit
    always_comb begin
        w_next_state = r_state;
        w_want       = 1'b0;
        w_advance    = 1'b0;
        w_set_fault  = 1'b0;
        case (r_state)
            RUN: begin
                w_want = w_run;
                if (!w_run) w_next_state = STEP_WAIT;
            end
            STEP_WAIT: begin
                w_want = w_step_rise;
                if (w_run) w_next_state = RUN;
            end
            default: ;
        endcase
        if (w_want) begin
            if (i_halt_req) begin
                w_next_state = HALT;
            end else if (i_redirect && (i_redirect_target[1:0] != 2'b00)) begin
                w_next_state = FAULT;
                w_set_fault  = 1'b1;
            end else begin
                w_advance = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_set_fault) r_fault <= 1'b1;
            if (w_advance) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_advance     = w_advance;
    assign o_state       = r_state;
    assign o_fault       = r_fault;
    assign o_instr_count = r_count;

endmodule
